// File: rtl/npu_pkg.sv
// npu_pkg: shared state type and constants for the NPU 3x3 convolution sequencer.
package npu_pkg;

    localparam int NPU_K        = 3;
    localparam int NPU_PE_W     = 24;
    localparam int NPU_IN_W_DEF = 15;

    // Cycles per output row with res_ready high: CLR, two primed columns, then 5 per result.
    localparam int NPU_ROW_COST = 1 + 2 * (NPU_K - 1) + 5 * (NPU_IN_W_DEF - (NPU_K - 1));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RD,
        ST_LD,
        ST_CALC,
        ST_CAP,
        ST_OUT,
        ST_DONE
    } npu_conv_seq_state_e;

endpackage

// File: rtl/npu_conv_seq_addr.sv
// npu_conv_seq_addr: window row/column counters and incremental column-buffer address.
module npu_conv_seq_addr
    import npu_pkg::*;
#(
    parameter int IN_H   = 16,
    parameter int IN_W   = 15,
    parameter int K      = NPU_K,
    parameter int ADDR_W = $clog2(IN_H * IN_W),
    parameter int ROW_W  = $clog2(IN_H),
    parameter int COL_W  = $clog2(IN_W)
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              i_clr,
    input  logic              i_col_inc,
    input  logic              i_row_inc,
    output logic [ROW_W-1:0]  o_row,
    output logic [COL_W-1:0]  o_col,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_col_primed,
    output logic              o_col_last,
    output logic              o_row_last
);

    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_addr;

    // (row, IN_W-1) -> (row+1, 0) is contiguous in the buffer, so a row wrap is also +1.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_clr) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_row_inc) begin
            r_row  <= r_row + 1'b1;
            r_col  <= '0;
            r_addr <= r_addr + 1'b1;
        end else if (i_col_inc) begin
            r_col  <= r_col + 1'b1;
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_addr       = r_addr;
    assign o_col_primed = (r_col >= COL_W'(K - 1));
    assign o_col_last   = (r_col == COL_W'(IN_W - 1));
    assign o_row_last   = (r_row >= ROW_W'(IN_H - K));

endmodule

// File: rtl/npu_conv_seq.sv
// npu_conv_seq: autonomous 3x3 convolution sequencer driving buffer, window, PE and result handshake.
// Optional stall counter enabled by defining NPU_CONV_SEQ_PERF_EN.
module npu_conv_seq
    import npu_pkg::*;
#(
    parameter int IN_H   = 16,
    parameter int IN_W   = 15,
    parameter int K      = NPU_K,
    parameter int ADDR_W = $clog2(IN_H * IN_W)
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       start,
    input  logic                       abort,
    output logic                       buf_rd_en,
    output logic [ADDR_W-1:0]          buf_rd_addr,
    output logic                       win_clear,
    output logic                       win_load_en,
    output logic                       pe_clear,
    output logic                       pe_ready,
    input  logic signed [NPU_PE_W-1:0] pe_sum_i,
    output logic signed [NPU_PE_W-1:0] res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(IN_H)-1:0]    row_idx,
    output logic [$clog2(IN_W)-1:0]    col_idx,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                perf_stall
);

    localparam int ROW_W = $clog2(IN_H);
    localparam int COL_W = $clog2(IN_W);

    npu_conv_seq_state_e r_state, w_next;

    logic                       w_cnt_clr;
    logic                       w_col_inc;
    logic                       w_row_inc;
    logic                       w_col_primed;
    logic                       w_col_last;
    logic                       w_row_last;
    logic signed [NPU_PE_W-1:0] r_res;

    npu_conv_seq_addr #(
        .IN_H   (IN_H),
        .IN_W   (IN_W),
        .K      (K),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_addr (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .i_clr        (w_cnt_clr),
        .i_col_inc    (w_col_inc),
        .i_row_inc    (w_row_inc),
        .o_row        (row_idx),
        .o_col        (col_idx),
        .o_addr       (buf_rd_addr),
        .o_col_primed (w_col_primed),
        .o_col_last   (w_col_last),
        .o_row_last   (w_row_last)
    );

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_col_inc   = 1'b0;
        w_row_inc   = 1'b0;
        buf_rd_en   = (r_state == ST_RD);
        win_clear   = (r_state == ST_CLR);
        win_load_en = (r_state == ST_LD);
        pe_clear    = (r_state == ST_LD);
        pe_ready    = (r_state == ST_CALC);
        res_valid   = (r_state == ST_OUT);
        done        = (r_state == ST_DONE);
        busy        = (r_state != ST_IDLE);
        if (abort) begin
            w_next    = ST_IDLE;
            w_cnt_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next    = ST_CLR;
                        w_cnt_clr = 1'b1;
                    end
                end
                ST_CLR:  w_next = ST_RD;
                ST_RD:   w_next = ST_LD;
                ST_LD: begin
                    if (!w_col_primed) begin
                        w_col_inc = 1'b1;
                        w_next    = ST_RD;
                    end else begin
                        w_next    = ST_CALC;
                    end
                end
                ST_CALC: w_next = ST_CAP;
                ST_CAP:  w_next = ST_OUT;
                ST_OUT: begin
                    if (res_ready) begin
                        if (!w_col_last) begin
                            w_col_inc = 1'b1;
                            w_next    = ST_RD;
                        end else if (!w_row_last) begin
                            w_row_inc = 1'b1;
                            w_next    = ST_CLR;
                        end else begin
                            w_next    = ST_DONE;
                        end
                    end
                end
                ST_DONE: w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res <= '0;
        end else if (r_state == ST_CAP) begin
            r_res <= pe_sum_i;
        end
    end

    assign res_data = r_res;

`ifdef NPU_CONV_SEQ_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf <= '0;
        end else if (w_cnt_clr) begin
            r_perf <= '0;
        end else if (res_valid && !res_ready && (r_perf != '1)) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_stall = r_perf;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_npu_conv_seq.sv
// Self-checking bench for npu_conv_seq: random PE sums and backpressure checked against
// a row-major sliding-window model of the image walk.
module tb_npu_conv_seq;
    import npu_pkg::*;

    localparam int IN_H     = 16;
    localparam int IN_W     = 15;
    localparam int K        = 3;
    localparam int ADDR_W   = $clog2(IN_H * IN_W);
    localparam int N_ROWS   = IN_H - K + 1;
    localparam int N_COLS   = IN_W - K + 1;
    localparam int N_RES    = N_ROWS * N_COLS;
    localparam int ROW_COST = 1 + 2 * (K - 1) + 5 * N_COLS;
    localparam int PASS_CYC = N_ROWS * ROW_COST + 1;
`ifdef NPU_CONV_SEQ_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       start = 1'b0;
    logic                       abort = 1'b0;
    logic                       res_ready = 1'b0;
    logic signed [NPU_PE_W-1:0] pe_sum_i = '0;
    logic                       buf_rd_en;
    logic [ADDR_W-1:0]          buf_rd_addr;
    logic                       win_clear, win_load_en, pe_clear, pe_ready;
    logic signed [NPU_PE_W-1:0] res_data;
    logic                       res_valid, busy, done;
    logic [$clog2(IN_H)-1:0]    row_idx;
    logic [$clog2(IN_W)-1:0]    col_idx;
    logic [15:0]                perf_stall;

    int n_tests = 0;
    int n_fail  = 0;

    int                  q_addr[$];
    logic [NPU_PE_W-1:0] q_res[$];
    logic [NPU_PE_W-1:0] q_exp[$];
    int                  q_row[$];
    int                  q_col[$];
    int   o_nclr, o_clr_before_row1, o_reads_first_valid, o_done_cyc, o_ndone;
    int   o_min_gap, o_stalls, o_stable_err, o_timeout, o_abort_row, o_abort_col;
    logic o_busy_first, o_busy_after_done, o_abort_busy, o_abort_valid;

    npu_conv_seq #(
        .IN_H   (IN_H),
        .IN_W   (IN_W),
        .K      (K),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .start       (start),
        .abort       (abort),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .win_clear   (win_clear),
        .win_load_en (win_load_en),
        .pe_clear    (pe_clear),
        .pe_ready    (pe_ready),
        .pe_sum_i    (pe_sum_i),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .row_idx     (row_idx),
        .col_idx     (col_idx),
        .busy        (busy),
        .done        (done),
        .perf_stall  (perf_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one pass from start; ready_mode 0 = always ready, 1 = 7-cycle hold on result 3, 2 = random.
    task automatic run_pass(input int ready_mode, input int abort_idx, input bit neg5);
        int   cyc;
        int   last_hs;
        int   hold_left;
        int   abort_cyc;
        bit   hold_prev;
        bit   cap_now;
        bit   fin;
        logic [NPU_PE_W-1:0] data_prev;
        q_addr.delete(); q_res.delete(); q_exp.delete(); q_row.delete(); q_col.delete();
        o_nclr = 0; o_clr_before_row1 = -1; o_reads_first_valid = -1;
        o_done_cyc = -1; o_ndone = 0; o_min_gap = 1 << 30; o_stalls = 0;
        o_stable_err = 0; o_timeout = 0; o_abort_row = -1; o_abort_col = -1;
        o_busy_after_done = 1'bx; o_abort_busy = 1'bx; o_abort_valid = 1'bx;
        last_hs = -1; hold_left = 7; abort_cyc = -1; hold_prev = 1'b0;
        cap_now = 1'b0; fin = 1'b0; data_prev = '0;
        start = 1'b1; abort = 1'b0; res_ready = 1'b1;
        pe_sum_i = NPU_PE_W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        o_busy_first = busy;
        cyc = 1;
        while (!fin) begin
            if (hold_prev && (res_valid !== 1'b1 || res_data !== data_prev)) o_stable_err++;
            if (win_clear === 1'b1) o_nclr++;
            if (buf_rd_en === 1'b1) begin
                if (int'(buf_rd_addr) == IN_W && o_clr_before_row1 < 0) o_clr_before_row1 = o_nclr;
                q_addr.push_back(int'(buf_rd_addr));
            end
            if (res_valid === 1'b1 && o_reads_first_valid < 0) o_reads_first_valid = q_addr.size();
            if (done === 1'b1) begin
                o_ndone++;
                if (o_done_cyc < 0) o_done_cyc = cyc;
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                o_abort_busy  = busy;
                o_abort_valid = res_valid;
                o_abort_row   = int'(row_idx);
                o_abort_col   = int'(col_idx);
            end
            if (o_done_cyc >= 0 && cyc == o_done_cyc + 1) begin
                o_busy_after_done = busy;
                fin = 1'b1;
            end
            if (abort_cyc >= 0 && cyc >= abort_cyc + 20) fin = 1'b1;
            if (cyc >= 4000) begin
                o_timeout = 1;
                fin = 1'b1;
            end
            if (!fin) begin
                abort = 1'b0;
                if (abort_idx >= 0 && abort_cyc < 0 && res_valid === 1'b1 && q_res.size() == abort_idx) begin
                    abort = 1'b1;
                    abort_cyc = cyc;
                end
                case (ready_mode)
                    0: res_ready = 1'b1;
                    1: begin
                        res_ready = 1'b1;
                        if (res_valid === 1'b1 && q_res.size() == 3 && hold_left > 0) begin
                            res_ready = 1'b0;
                            hold_left--;
                        end
                    end
                    default: res_ready = ($urandom_range(0, 2) != 0);
                endcase
                // The cycle after the pe_ready pulse is the capture cycle.
                if (cap_now) begin
                    pe_sum_i = (neg5 && q_exp.size() == 0) ? 24'hFFFFFB : NPU_PE_W'($urandom);
                    q_exp.push_back(pe_sum_i);
                end else begin
                    pe_sum_i = NPU_PE_W'($urandom);
                end
                cap_now = (pe_ready === 1'b1);
                if (abort == 1'b0 && res_valid === 1'b1) begin
                    if (res_ready) begin
                        q_res.push_back(res_data);
                        q_row.push_back(int'(row_idx));
                        q_col.push_back(int'(col_idx));
                        if (last_hs >= 0 && cyc - last_hs < o_min_gap) o_min_gap = cyc - last_hs;
                        last_hs = cyc;
                    end else begin
                        o_stalls++;
                    end
                end
                hold_prev = (abort == 1'b0) && (res_valid === 1'b1) && !res_ready;
                data_prev = res_data;
                @(posedge clk); #1;
                cyc++;
            end
        end
        abort = 1'b0;
        res_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        n_tests++;
        if ({buf_rd_en, win_clear, win_load_en, pe_clear, pe_ready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {buf_rd_en, win_clear, win_load_en, pe_clear, pe_ready});
        end
        n_tests++;
        if ({res_valid, done, busy} !== 3'b0) begin
            n_fail++; $display("FAIL reset_status: got %b expected 000", {res_valid, done, busy});
        end
        n_tests++;
        if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data: got %h expected 000000", res_data); end
        n_tests++;
        if (buf_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", buf_rd_addr); end
        n_tests++;
        if ({row_idx, col_idx} !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d/%0d expected 0/0", row_idx, col_idx); end
        n_tests++;
        if (perf_stall !== '0) begin n_fail++; $display("FAIL reset_perf: got %0d expected 0", perf_stall); end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_without_start: busy got %b expected 0", busy); end
    endtask

    task automatic test_full_pass();
        int er[$];
        int ec[$];
        for (int r = 0; r < N_ROWS; r++)
            for (int c = K - 1; c < IN_W; c++) begin
                er.push_back(r);
                ec.push_back(c);
            end
        run_pass(0, -1, 1'b1);
        n_tests++;
        if (o_busy_first !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b expected 1", o_busy_first); end
        n_tests++;
        if (q_res.size() != N_RES) begin n_fail++; $display("FAIL handshake_count: got %0d expected %0d", q_res.size(), N_RES); end
        n_tests++;
        if (o_ndone != 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", o_ndone); end
        n_tests++;
        if (o_done_cyc != PASS_CYC) begin n_fail++; $display("FAIL done_cycle: got %0d expected %0d", o_done_cyc, PASS_CYC); end
        n_tests++;
        if (o_busy_after_done !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b expected 0", o_busy_after_done); end
        n_tests++;
        if (o_min_gap != 5) begin n_fail++; $display("FAIL result_spacing: got %0d expected 5", o_min_gap); end
        n_tests++;
        if (perf_stall !== '0) begin n_fail++; $display("FAIL perf_no_stall: got %0d expected 0", perf_stall); end
        for (int i = 0; i < q_row.size() && i < er.size(); i++) begin
            n_tests++;
            if (q_row[i] != er[i] || q_col[i] != ec[i]) begin
                n_fail++; $display("FAIL result_pos[%0d]: got r%0d c%0d expected r%0d c%0d", i, q_row[i], q_col[i], er[i], ec[i]);
            end
        end
    endtask

    task automatic test_address_trace();
        int ea[$];
        for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < IN_W; c++) ea.push_back(r * IN_W + c);
        n_tests++;
        if (q_addr.size() != ea.size()) begin n_fail++; $display("FAIL read_count: got %0d expected %0d", q_addr.size(), ea.size()); end
        for (int i = 0; i < q_addr.size() && i < ea.size(); i++) begin
            n_tests++;
            if (q_addr[i] != ea[i]) begin n_fail++; $display("FAIL read_addr[%0d]: got %0d expected %0d", i, q_addr[i], ea[i]); end
        end
        n_tests++;
        if (o_reads_first_valid != K) begin n_fail++; $display("FAIL reads_before_first_valid: got %0d expected %0d", o_reads_first_valid, K); end
        n_tests++;
        if (o_clr_before_row1 != 2) begin n_fail++; $display("FAIL clears_before_row1: got %0d expected 2", o_clr_before_row1); end
        n_tests++;
        if (o_nclr != N_ROWS) begin n_fail++; $display("FAIL clear_count: got %0d expected %0d", o_nclr, N_ROWS); end
    endtask

    task automatic test_data_capture();
        n_tests++;
        if (q_res.size() == 0 || q_res[0] !== 24'hFFFFFB) begin
            n_fail++; $display("FAIL first_result_neg5: got %h expected fffffb", (q_res.size() == 0) ? 24'h0 : q_res[0]);
        end
        n_tests++;
        if (q_exp.size() != q_res.size()) begin n_fail++; $display("FAIL capture_count: got %0d expected %0d", q_res.size(), q_exp.size()); end
        for (int i = 0; i < q_res.size() && i < q_exp.size(); i++) begin
            n_tests++;
            if (q_res[i] !== q_exp[i]) begin n_fail++; $display("FAIL res_data[%0d]: got %h expected %h", i, q_res[i], q_exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        run_pass(1, -1, 1'b0);
        n_tests++;
        if (o_stalls != 7) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 7", o_stalls); end
        n_tests++;
        if (o_stable_err != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes expected 0", o_stable_err); end
        n_tests++;
        if (o_done_cyc != PASS_CYC + 7) begin n_fail++; $display("FAIL bp_pass_length: got %0d expected %0d", o_done_cyc, PASS_CYC + 7); end
        n_tests++;
        if (q_res.size() != N_RES) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected %0d", q_res.size(), N_RES); end
        n_tests++;
        if (perf_stall !== (PERF_EN ? 16'd7 : 16'd0)) begin
            n_fail++; $display("FAIL bp_perf_stall: got %0d expected %0d", perf_stall, PERF_EN ? 7 : 0);
        end
        for (int i = 0; i < q_res.size() && i < q_exp.size(); i++) begin
            n_tests++;
            if (q_res[i] !== q_exp[i]) begin n_fail++; $display("FAIL bp_res_data[%0d]: got %h expected %h", i, q_res[i], q_exp[i]); end
        end
    endtask

    task automatic test_random_backpressure();
        int exp_perf;
        run_pass(2, -1, 1'b0);
        exp_perf = PERF_EN ? ((o_stalls > 65535) ? 65535 : o_stalls) : 0;
        n_tests++;
        if (q_res.size() != N_RES) begin n_fail++; $display("FAIL rnd_handshakes: got %0d expected %0d", q_res.size(), N_RES); end
        n_tests++;
        if (o_done_cyc != PASS_CYC + o_stalls) begin
            n_fail++; $display("FAIL rnd_pass_length: got %0d expected %0d", o_done_cyc, PASS_CYC + o_stalls);
        end
        n_tests++;
        if (o_stable_err != 0) begin n_fail++; $display("FAIL rnd_hold_stable: got %0d changes expected 0", o_stable_err); end
        n_tests++;
        if (int'(perf_stall) != exp_perf) begin n_fail++; $display("FAIL rnd_perf_stall: got %0d expected %0d", perf_stall, exp_perf); end
        n_tests++;
        if (o_ndone != 1) begin n_fail++; $display("FAIL rnd_done_count: got %0d expected 1", o_ndone); end
        for (int i = 0; i < q_res.size() && i < q_exp.size(); i++) begin
            n_tests++;
            if (q_res[i] !== q_exp[i]) begin n_fail++; $display("FAIL rnd_res_data[%0d]: got %h expected %h", i, q_res[i], q_exp[i]); end
        end
    endtask

    task automatic test_abort();
        run_pass(0, 50, 1'b0);
        n_tests++;
        if (o_timeout != 0) begin n_fail++; $display("FAIL abort_reached: got timeout expected abort on result 50"); end
        n_tests++;
        if ({o_abort_busy, o_abort_valid} !== 2'b00) begin
            n_fail++; $display("FAIL abort_idle: busy/valid got %b%b expected 00", o_abort_busy, o_abort_valid);
        end
        n_tests++;
        if (o_abort_row != 0 || o_abort_col != 0) begin
            n_fail++; $display("FAIL abort_counters: got r%0d c%0d expected r0 c0", o_abort_row, o_abort_col);
        end
        n_tests++;
        if (o_ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", o_ndone); end
        n_tests++;
        if (q_res.size() != 50) begin n_fail++; $display("FAIL abort_handshakes: got %0d expected 50", q_res.size()); end
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: busy got %b expected 0", busy); end
        run_pass(0, -1, 1'b0);
        n_tests++;
        if (q_addr.size() == 0 || q_addr[0] != 0) begin
            n_fail++; $display("FAIL restart_first_addr: got %0d expected 0", (q_addr.size() == 0) ? -1 : q_addr[0]);
        end
        n_tests++;
        if (q_addr.size() != N_ROWS * IN_W) begin n_fail++; $display("FAIL restart_reads: got %0d expected %0d", q_addr.size(), N_ROWS * IN_W); end
        n_tests++;
        if (q_res.size() != N_RES) begin n_fail++; $display("FAIL restart_handshakes: got %0d expected %0d", q_res.size(), N_RES); end
        n_tests++;
        if (o_done_cyc != PASS_CYC || o_ndone != 1) begin
            n_fail++; $display("FAIL restart_done: got cycle %0d count %0d expected cycle %0d count 1", o_done_cyc, o_ndone, PASS_CYC);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        int guard;
        int ndone;
        seen = 0; guard = 0; ndone = 0;
        start = 1'b1; res_ready = 1'b1; pe_sum_i = 24'h123456;
        @(posedge clk); #1;
        start = 1'b0;
        while (seen < 2 && guard < 500) begin
            if (pe_ready === 1'b1) seen++;
            if (seen < 2) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        n_tests++;
        if (seen != 2) begin n_fail++; $display("FAIL async_reach_calc: got %0d pe_ready pulses expected 2", seen); end
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({buf_rd_en, win_clear, win_load_en, pe_clear, pe_ready} !== 5'b0) begin
            n_fail++; $display("FAIL async_strobes: got %b expected 00000", {buf_rd_en, win_clear, win_load_en, pe_clear, pe_ready});
        end
        n_tests++;
        if ({res_valid, done, busy} !== 3'b0) begin
            n_fail++; $display("FAIL async_status: got %b expected 000", {res_valid, done, busy});
        end
        n_tests++;
        if (res_data !== '0) begin n_fail++; $display("FAIL async_res_data: got %h expected 000000", res_data); end
        n_tests++;
        if (buf_rd_addr !== '0 || {row_idx, col_idx} !== '0) begin
            n_fail++; $display("FAIL async_counters: got addr %0d r%0d c%0d expected 0 r0 c0", buf_rd_addr, row_idx, col_idx);
        end
        n_tests++;
        if (perf_stall !== '0) begin n_fail++; $display("FAIL async_perf: got %0d expected 0", perf_stall); end
        #2;
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        n_tests++;
        if (busy !== 1'b0 || ndone != 0) begin
            n_fail++; $display("FAIL async_stays_idle: busy %b done pulses %0d expected busy 0 pulses 0", busy, ndone);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_address_trace();
        test_data_capture();
        test_backpressure();
        test_random_backpressure();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
